// File: rtl/fpu_arbiter_pkg.sv
// Shared definitions for the fpu_double arbiter: FPU op codes, rounding-mode
// codes, FSM state constants and the latched command struct.
package fpu_arbiter_pkg;

  localparam logic [2:0] FPU_ADD = 3'd0;
  localparam logic [2:0] FPU_SUB = 3'd1;
  localparam logic [2:0] FPU_MUL = 3'd2;
  localparam logic [2:0] FPU_DIV = 3'd3;

  localparam logic [1:0] RMODE_NEAREST = 2'd0;
  localparam logic [1:0] RMODE_ZERO    = 2'd1;
  localparam logic [1:0] RMODE_POS_INF = 2'd2;
  localparam logic [1:0] RMODE_NEG_INF = 2'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  // operation captured from the winning requester at grant time
  typedef struct packed {
    logic [2:0]  op;
    logic [63:0] opa;
    logic [63:0] opb;
  } fpu_cmd_t;

endpackage

// File: rtl/fpu_arbiter_if.sv
// Bus between the requesters / fpu_double and the arbiter.
//   requester side : req, req_op, req_opa, req_opb -> done, err, result, busy
//   fpu side       : fpu_enable, fpu_rst, fpu_op, fpu_rmode, fpu_opa, fpu_opb
//                    <- fpu_out, fpu_ready
// master = the arbiter, slave = requesters plus the FPU.
interface fpu_arbiter_if #(parameter int NREQ = 3);
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0][2:0]   req_op;
  logic [NREQ-1:0][63:0]  req_opa;
  logic [NREQ-1:0][63:0]  req_opb;
  logic [NREQ-1:0]        done;
  logic [NREQ-1:0]        err;
  logic [63:0]            result;
  logic                   busy;
  logic                   fpu_enable;
  logic                   fpu_rst;
  logic [2:0]             fpu_op;
  logic [1:0]             fpu_rmode;
  logic [63:0]            fpu_opa;
  logic [63:0]            fpu_opb;
  logic [63:0]            fpu_out;
  logic                   fpu_ready;

  modport master (
    input  req, req_op, req_opa, req_opb, fpu_out, fpu_ready,
    output done, err, result, busy,
           fpu_enable, fpu_rst, fpu_op, fpu_rmode, fpu_opa, fpu_opb
  );

  modport slave (
    output req, req_op, req_opa, req_opb, fpu_out, fpu_ready,
    input  done, err, result, busy,
           fpu_enable, fpu_rst, fpu_op, fpu_rmode, fpu_opa, fpu_opb
  );
endinterface

// File: rtl/fpu_arbiter_rr_pick.sv
// Round-robin priority picker.
//   req        : request vector
//   last_grant : index granted last time; search starts one above it
//   grant      : first requesting index found, wrapping at NREQ
//   valid      : any request present
module rr_pick #(
  parameter int NREQ  = 3,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] grant,
  output logic             valid
);

  // one extra bit so last_grant + NREQ cannot overflow before the wrap
  logic [IDX_W:0] idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (IDX_W+1)'(last_grant) + (IDX_W+1)'(k);
      if (idx >= (IDX_W+1)'(NREQ)) idx = idx - (IDX_W+1)'(NREQ);
      if (!valid && req[idx[IDX_W-1:0]]) begin
        valid = 1'b1;
        grant = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fpu_arbiter.sv
// Shares one fpu_double among NREQ requesters.
//   clk, reset : clock, synchronous active-high reset
//   bus        : fpu_arbiter_if.master (requester handshake + FPU drive)
// IDLE grants round-robin and latches the winner's operation, WAIT keeps the
// FPU enabled until fpu_ready or TIMEOUT cycles, CLEAR resets the FPU for one
// cycle and carries the done/err pulse.
module fpu_arbiter
  import fpu_arbiter_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 255
) (
  input logic           clk,
  input logic           reset,
  fpu_arbiter_if.master bus
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [1:0]       state;
  logic [IDX_W-1:0] last_grant;   // doubles as the active grant during WAIT
  logic [IDX_W-1:0] pick;
  logic             pick_vld;
  logic [CNT_W-1:0] wait_cnt;
  fpu_cmd_t         cmd;
  logic [NREQ-1:0]  done_q;
  logic [NREQ-1:0]  err_q;
  logic [63:0]      result_q;
  logic [NREQ-1:0]  grant_oh;

  rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
    .req        (bus.req),
    .last_grant (last_grant),
    .grant      (pick),
    .valid      (pick_vld)
  );

  assign grant_oh = NREQ'(1) << last_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= IDX_W'(NREQ - 1);
      wait_cnt   <= '0;
      cmd        <= '0;
      done_q     <= '0;
      err_q      <= '0;
      result_q   <= '0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            last_grant <= pick;
            cmd        <= '{op: bus.req_op[pick], opa: bus.req_opa[pick],
                            opb: bus.req_opb[pick]};
            wait_cnt   <= '0;
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // a ready in the last counted cycle still wins over the timeout
          if (bus.fpu_ready) begin
            result_q <= bus.fpu_out;
            done_q   <= grant_oh;
            state    <= ST_CLEAR;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            done_q <= grant_oh;
            err_q  <= grant_oh;
            state  <= ST_CLEAR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_CLEAR: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.result     = result_q;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.fpu_enable = (state == ST_WAIT);
  // combinational so the FPU is held in reset from the first reset cycle
  assign bus.fpu_rst    = reset | (state == ST_CLEAR);
  assign bus.fpu_op     = cmd.op;
  assign bus.fpu_opa    = cmd.opa;
  assign bus.fpu_opb    = cmd.opb;
  assign bus.fpu_rmode  = RMODE_NEAREST;

endmodule
